gpio_in_filter: RTL and testbench
=================================

# gpio_in_filter

Input-conditioning stage between the tile input pins (`ui_in`/`uio_in` GPIO bits) and `retrosoc_tiny.gpio_in_i`. It synchronises each raw GPIO input into `clk_i` and applies a per-bit programmable glitch filter. It produces one-cycle rise/fall pulses and, optionally, sticky edge-interrupt pending bits. Its `gpio_o` drives the SoC's GPIO input bus directly.

## Interface
- `WIDTH`, 9: number of GPIO bits conditioned; bits 0..8 are the pin-mapped ones.
- `CNT_W`, 4: filter counter width; maximum filter length is 2^CNT_W-1.
- `clk_i` in 1: single clock, the SoC clock.
- `rst_n_i` in 1: reset, asynchronous and active-low.
- `gpio_raw_i` in WIDTH: asynchronous pin levels.
- `filt_en_i` in WIDTH: per-bit filter enable; 0 means bypass.
- `filt_len_i` in CNT_W: shared filter length in cycles.
- `rise_en_i` in WIDTH: per-bit rising-edge interrupt enable.
- `fall_en_i` in WIDTH: per-bit falling-edge interrupt enable.
- `irq_clr_i` in WIDTH: per-bit write-1-to-clear pulse for pending bits.
- `gpio_o` in→out WIDTH: conditioned level, feeds `gpio_in_i`.
- `rise_o` out WIDTH: one-cycle pulse on a 0→1 change of `gpio_o`.
- `fall_o` out WIDTH: one-cycle pulse on a 1→0 change of `gpio_o`.
- `irq_pend_o` out WIDTH: sticky pending bits.
- `irq_o` out 1: OR-reduction of `irq_pend_o`.

## Operation
- Synchroniser: two flops per bit, `sync1 <= gpio_raw_i` then `sync2 <= sync1`. No logic between the two flops.
- Stable register `st[i]` drives `gpio_o[i]`. Each bit has a counter `cnt[i]` of width CNT_W.
- Bypass (`filt_en_i[i]=0`):
  - `st <= sync2` every cycle.
  - `cnt <= 0`.
- Filtered (`filt_en_i[i]=1`):
  - If `sync2 == st`: `cnt <= 0`.
  - Else if `cnt >= filt_len_i`: `st <= sync2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - Net effect: `st` changes only after sync2 has disagreed with it for `filt_len_i+1` consecutive cycles.
  - Any agreeing cycle restarts the count, which rejects glitches.
  - The `>=` compare means that lowering `filt_len_i` while a count is in progress commits on the next disagreeing cycle. The counter never wraps.
- Edge pulses are registered from the `st` next-value versus the current `st`:
  - `rise_o <= st_next & ~st`.
  - `fall_o <= ~st_next & st`.
  - The pulse is high in exactly the first cycle `gpio_o` shows the new level.
- Toggling `filt_en_i` mid-count: `cnt` clears, bypass takes effect on the same edge, and no spurious edge is produced beyond the real level change.
- Pending bits (when compiled in):
  - Set when `(rise_o & rise_en_i) | (fall_o & fall_en_i)`.
  - Cleared by `irq_clr_i`.
  - Set wins over a simultaneous clear.
  - Bits are independent of each other.

## Timing
- Reset values: all outputs 0, including `sync1`/`sync2`/`st`/`cnt` and edge and pend registers.
- A pin already high when `rst_n_i` rises produces a normal rise event after the standard latency. Software must clear it.
- Latency from raw edge (setup met) to `gpio_o`: bypass is 3 clk edges; filtered is `3 + filt_len_i` edges. `filt_len_i=0` therefore equals bypass.
- `rise_o`/`fall_o`: coincident with the `gpio_o` change, 1 cycle wide.
- `irq_pend_o`: set 1 cycle after the edge pulse. `irq_o` is combinational from the pend flops.
- A clear takes effect on the next edge.
- Pulses shorter than `filt_len_i+1` cycles after synchronisation never reach `gpio_o`.
- Asynchronous reset mid-count: counters and state clear immediately. No pulse is generated on reset release except from the rule above.

## Configuration
- `GPIO_IN_FILTER_IRQ_EN`:
  - Defined: pending registers, `rise_en_i`/`fall_en_i`/`irq_clr_i` logic and `irq_o` are built as described.
  - Undefined: `irq_pend_o` is tied to all-zero and `irq_o` to 0. The enable and clear inputs are ignored. Filtering and edge pulses are unchanged.

## Test plan
- Reset then bypass, raw bit1 0→1 at edge 0 → `gpio_o[1]`=1 and `rise_o[1]`=1 at edge 3, `rise_o[1]`=0 at edge 4.
- `filt_en_i[2]`=1, `filt_len_i`=4:
  - 3-cycle high glitch → `gpio_o[2]` stays 0, no `rise_o`.
  - Steady high → `gpio_o[2]`=1 at edge 7.
- `filt_len_i`=8, lowered to 2 after cnt reaches 5 → commit on the next disagreeing cycle, single `rise_o` pulse.
- `rise_en_i[0]`=1, `fall_en_i[0]`=0, toggle bit0 high then low:
  - Rise → `irq_pend_o[0]`=1 and `irq_o`=1.
  - Fall → no change.
  - `irq_clr_i[0]` → 0 next cycle.
- Clear coincident with a new enabled edge → `irq_pend_o` stays 1. Built without the macro → `irq_pend_o`=0 and `irq_o`=0 throughout.
- Raw held high across reset release, bypass → rise pulse at edge 3. Reset asserted mid-count → all outputs 0 immediately.

Source files
------------

// File: rtl/gpio_in_filter.sv
// gpio_in_filter: 2-flop sync, per-bit glitch filter, rise/fall pulses for the SoC GPIO inputs.
// Define GPIO_IN_FILTER_IRQ_EN to build the sticky edge-interrupt pending bits and irq_o.
module gpio_in_filter #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] gpio_raw_i,
  input  logic [WIDTH-1:0] filt_en_i,
  input  logic [CNT_W-1:0] filt_len_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] irq_pend_o,
  output logic             irq_o
);
  logic [WIDTH-1:0] sync1, sync2, st, st_next;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  // when sync2 agrees with st, taking sync2 is the same as holding st
  always_comb begin
    st_next = st;
    for (int i = 0; i < WIDTH; i++) begin
      st_next[i] = (!filt_en_i[i] || cnt[i] >= filt_len_i) ? sync2[i] : st[i];
      cnt_next[i] = (!filt_en_i[i] || sync2[i] == st[i] || cnt[i] >= filt_len_i) ? '0 : cnt[i] + 1'b1;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= '0;
      sync2 <= '0;
      st <= '0;
      rise_o <= '0;
      fall_o <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= gpio_raw_i;
      sync2 <= sync1;
      st <= st_next;
      rise_o <= st_next & ~st;
      fall_o <= ~st_next & st;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end
  assign gpio_o = st;
`ifdef GPIO_IN_FILTER_IRQ_EN
  logic [WIDTH-1:0] pend;
  // set has priority over a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) pend <= '0;
    else pend <= (pend & ~irq_clr_i) | (rise_o & rise_en_i) | (fall_o & fall_en_i);
  end
  assign irq_pend_o = pend;
  assign irq_o = |pend;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{rise_en_i, fall_en_i, irq_clr_i};
  assign irq_pend_o = '0;
  assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_gpio_in_filter.sv
// tb_gpio_in_filter: directed plan cases plus random stimulus against a cycle-level reference model.
module tb_gpio_in_filter;
  localparam int W = 9;
`ifdef GPIO_IN_FILTER_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n_i = 1'b0;
  logic [W-1:0] gpio_raw_i = '0, filt_en_i = '0, rise_en_i = '0, fall_en_i = '0, irq_clr_i = '0;
  logic [3:0] filt_len_i = '0;
  logic [W-1:0] gpio_o, rise_o, fall_o, irq_pend_o;
  logic irq_o;
  int n_tests = 0, n_fail = 0;

  gpio_in_filter #(.WIDTH(W), .CNT_W(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .gpio_raw_i(gpio_raw_i), .filt_en_i(filt_en_i),
    .filt_len_i(filt_len_i), .rise_en_i(rise_en_i), .fall_en_i(fall_en_i), .irq_clr_i(irq_clr_i),
    .gpio_o(gpio_o), .rise_o(rise_o), .fall_o(fall_o), .irq_pend_o(irq_pend_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference: raw delayed two samples, then a level commits once it has
  // disagreed for more than filt_len consecutive samples
  logic [W-1:0] m_raw1, m_raw2, m_lvl, m_rise, m_fall, m_pend;
  int m_run [W];

  task automatic m_reset;
    m_raw1 = '0; m_raw2 = '0; m_lvl = '0; m_rise = '0; m_fall = '0; m_pend = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
  endtask

  task automatic m_step;
    logic [W-1:0] nl;
    for (int i = 0; i < W; i++) begin
      nl[i] = m_lvl[i];
      if (!filt_en_i[i]) begin
        nl[i] = m_raw2[i];
        m_run[i] = 0;
      end else if (m_raw2[i] == m_lvl[i]) m_run[i] = 0;
      else begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] > int'(filt_len_i)) begin
          nl[i] = m_raw2[i];
          m_run[i] = 0;
        end
      end
    end
    m_pend = IRQ ? ((m_pend & ~irq_clr_i) | (m_rise & rise_en_i) | (m_fall & fall_en_i)) : '0;
    m_rise = nl & ~m_lvl;
    m_fall = ~nl & m_lvl;
    m_lvl = nl;
    m_raw2 = m_raw1;
    m_raw1 = gpio_raw_i;
  endtask

  task automatic tick;
    m_step;
    @(posedge clk);
    #1;
    chk("gpio", gpio_o, m_lvl);
    chk("rise", rise_o, m_rise);
    chk("fall", fall_o, m_fall);
    chk("pend", irq_pend_o, m_pend);
    chk("irq", irq_o, |m_pend);
  endtask

  task automatic async_reset;
    rst_n_i = 1'b0;
    #1;
    m_reset;
    chk("rst_gpio", gpio_o, 0);
    chk("rst_rise", rise_o, 0);
    chk("rst_fall", fall_o, 0);
    chk("rst_pend", irq_pend_o, 0);
    chk("rst_irq", irq_o, 0);
    #2 rst_n_i = 1'b1;
  endtask

  initial begin
    logic seen;
    m_reset;
    @(posedge clk);
    #1;
    async_reset;
    // bypass latency
    gpio_raw_i[1] = 1'b1;
    tick; tick;
    chk("byp_e2_gpio", gpio_o[1], 0);
    tick;
    chk("byp_e3_gpio", gpio_o[1], 1);
    chk("byp_e3_rise", rise_o[1], 1);
    tick;
    chk("byp_e4_rise", rise_o[1], 0);
    gpio_raw_i[1] = 1'b0;
    repeat (4) tick;
    // glitch rejection, len 4
    filt_en_i[2] = 1'b1;
    filt_len_i = 4'd4;
    gpio_raw_i[2] = 1'b1;
    repeat (3) tick;
    gpio_raw_i[2] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      seen |= rise_o[2] | gpio_o[2];
    end
    chk("glitch_rejected", seen, 0);
    gpio_raw_i[2] = 1'b1;
    repeat (6) tick;
    chk("filt_e6_gpio", gpio_o[2], 0);
    tick;
    chk("filt_e7_gpio", gpio_o[2], 1);
    chk("filt_e7_rise", rise_o[2], 1);
    // lowering the length mid-count
    filt_en_i[3] = 1'b1;
    filt_len_i = 4'd8;
    gpio_raw_i[3] = 1'b1;
    repeat (7) tick;
    chk("lower_pre_gpio", gpio_o[3], 0);
    filt_len_i = 4'd2;
    tick;
    chk("lower_gpio", gpio_o[3], 1);
    chk("lower_rise", rise_o[3], 1);
    tick;
    chk("lower_rise_once", rise_o[3], 0);
    filt_en_i = '0;
    filt_len_i = '0;
    gpio_raw_i = '0;
    repeat (4) tick;
    // pending bits
    rise_en_i[0] = 1'b1;
    gpio_raw_i[0] = 1'b1;
    repeat (3) tick;
    chk("irq_rise", rise_o[0], 1);
    tick;
    chk("irq_pend_set", irq_pend_o[0], IRQ);
    chk("irq_out", irq_o, IRQ);
    gpio_raw_i[0] = 1'b0;
    repeat (5) tick;
    chk("irq_fall_hold", irq_pend_o[0], IRQ);
    irq_clr_i[0] = 1'b1;
    tick;
    irq_clr_i[0] = 1'b0;
    chk("irq_cleared", irq_pend_o[0], 0);
    gpio_raw_i[0] = 1'b1;
    repeat (3) tick;
    irq_clr_i[0] = 1'b1;
    tick;
    irq_clr_i[0] = 1'b0;
    chk("irq_set_wins", irq_pend_o[0], IRQ);
    irq_clr_i = '1;
    rise_en_i = '0;
    tick;
    irq_clr_i = '0;
    // pins high across reset release
    gpio_raw_i = '1;
    async_reset;
    tick; tick;
    chk("rel_e2_gpio", gpio_o, 0);
    tick;
    chk("rel_e3_gpio", gpio_o, 9'h1ff);
    chk("rel_e3_rise", rise_o, 9'h1ff);
    // reset mid-count
    filt_en_i = '1;
    filt_len_i = 4'd9;
    gpio_raw_i = '0;
    repeat (5) tick;
    async_reset;
    // random phase
    for (int n = 0; n < 4000; n++) begin
      gpio_raw_i ^= W'($urandom & $urandom & $urandom);
      if (n % 64 == 0) begin
        filt_en_i = W'($urandom);
        filt_len_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
        rise_en_i = W'($urandom);
        fall_en_i = W'($urandom);
      end
      if ($urandom_range(0, 49) == 0) filt_en_i ^= W'(1 << $urandom_range(0, W - 1));
      if ($urandom_range(0, 29) == 0) filt_len_i = 4'($urandom);
      irq_clr_i = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
      if ($urandom_range(0, 499) == 0) async_reset;
      tick;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
